ti_sbox: RTL and testbench
==========================

TI_SBOX -- requirements
Module: ti_sbox

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, nonzero reset seed of the internal mask LFSR.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  tile enable; ignored, the block operates regardless.
REQ-005 ui_in  input  8  data share byte captured during load.
REQ-006 uo_out  output  8  output share byte; 8'h00 whenever out_ready=0.
REQ-007 uio_in  input  8  bit0 in_load strobe; bit1 inverse select (see Configuration); other bits ignored.
REQ-008 uio_out  output  8  bit3 out_ready, bit4 busy; all other bits 0.
REQ-009 uio_oe  output  8  constant 8'h18.

Function
REQ-010 The block computes the AES S-box on a 3-share Boolean-masked byte using a threshold implementation; the unmasked value is never held in any register.
REQ-011 FSM states IDLE, LOAD, CALC, OUT; a share counter k (0..2) tracks loading.
REQ-012 In IDLE/LOAD, each rising edge with in_load=1 captures ui_in as share x_k and increments k; in_load=0 holds k; input x = x0^x1^x2.
REQ-013 Edge capturing x2 is E0; busy=1 from after E0 until after E7; in_load is ignored while busy=1; first new share may be captured at E8.
REQ-014 CALC spans edges E1..E4 (4 pipeline register stages, each nonlinear stage followed by a register).
REQ-015 After E4, E5, E6: out_ready=1 and uo_out = y0, y1, y2 respectively; after E7 out_ready=0, uo_out=0, state IDLE, k=0.
REQ-016 Output shares satisfy y0^y1^y2 = Sbox(x) for all 256 x and all share splits.
REQ-017 Fresh randomness: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advances every cycle, reshares between stages; individual y shares are not required to be deterministic per x.
REQ-018 out_ready is asserted for exactly 3 consecutive cycles per computation; never without a completed 3-share load.

Reset
REQ-019 rst_n=0 forces immediately: state IDLE, k=0, all share/pipeline registers 0, uo_out=0, out_ready=0, busy=0, LFSR=LFSR_SEED.
REQ-020 Reset during LOAD, CALC or OUT aborts the operation; no out_ready pulse follows for it.

Configuration
REQ-021 Macro SBOX_INV_EN: when defined, uio_in[1] sampled with share x0 selects inverse S-box (y = InvSbox(x)) for that computation, same latency.
REQ-022 Without SBOX_INV_EN, uio_in[1] is ignored and only the forward S-box is built.

Structure
REQ-023 Package ti_sbox_pkg holds: FSM state enum, NUM_SHARES=3, PIPE_DEPTH=4, LFSR polynomial constant, default seed, affine-transform constants (forward 8'h63, inverse 8'h05).
REQ-024 One sub-module ti_sbox_core: shared tower-field GF((2^4)^2) inversion datapath with pipeline registers and reshare inputs; top-level ti_sbox holds FSM, share capture, LFSR and output serializer.

Verification
REQ-025 Assert rst_n=0 -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'h18; release, idle 5 cycles -> out_ready stays 0.
REQ-026 Load shares 8'h00, 8'h00, 8'h00 -> out_ready high exactly after E4..E6, XOR of the three uo_out bytes = 8'h63.
REQ-027 Load 8'h12, 8'h41, 8'h00 (x=8'h53) with in_load gaps between shares -> XOR = 8'hED.
REQ-028 Load 8'hAA, 8'h55, 8'h00 (x=8'hFF), keep in_load=1 with ui_in=8'h77 during busy -> XOR = 8'h16, extra bytes ignored, next computation unaffected.
REQ-029 Load shares, pull rst_n low at E2 -> no out_ready; then load 8'h01, 8'h00, 8'h00 -> XOR = 8'h7C.
REQ-030 x=8'h63 with uio_in[1]=1 -> XOR = 8'h00 with SBOX_INV_EN defined, 8'hFB without it.

Source files
------------

// File: rtl/ti_sbox_pkg.sv
// Shared types, constants and GF(2^8) helpers for the 3-share threshold AES S-box.
// Also used by the optional inverse S-box path, which is enabled by SBOX_INV_EN.
package ti_sbox_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_e;

  localparam int          NUM_SHARES        = 3;
  localparam int          PIPE_DEPTH        = 4;
  localparam logic [15:0] LFSR_POLY         = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shift Galois
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam logic [7:0]  AFF_FWD_C         = 8'h63;
  localparam logic [7:0]  AFF_INV_C         = 8'h05;

  typedef logic [NUM_SHARES-1:0][7:0] shares_t;

  // Multiplication modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1B);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Linear parts of the affine maps; the constant is added on one share only.
  function automatic logic [7:0] aff_fwd_lin(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4);
  endfunction

  function automatic logic [7:0] aff_inv_lin(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6);
  endfunction

endpackage

// File: rtl/ti_sbox_core.sv
// Shared GF(2^8) inversion viewed as a quadratic extension of GF(2^4): a^-1 = a^16 * N^14 with norm
// N = a^17 in the GF(2^4) subfield; four TI multiplier stages, each resharing into a register. SBOX_INV_EN adds inverse mode.
module ti_sbox_core
  import ti_sbox_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        inv_i,
  input  logic [15:0] rnd_i,
  input  shares_t     x_i,
  output shares_t     y_o
);

  // Non-complete 3-share product: output share i never sees input share i.
  function automatic shares_t ti_mul(input shares_t a, input shares_t b);
    shares_t c;
    c[0] = gf_mul(a[1], b[1]) ^ gf_mul(a[1], b[2]) ^ gf_mul(a[2], b[1]);
    c[1] = gf_mul(a[2], b[2]) ^ gf_mul(a[2], b[0]) ^ gf_mul(a[0], b[2]);
    c[2] = gf_mul(a[0], b[0]) ^ gf_mul(a[0], b[1]) ^ gf_mul(a[1], b[0]);
    return c;
  endfunction

  function automatic shares_t reshare(input shares_t c, input logic [15:0] r);
    shares_t o;
    o[0] = c[0] ^ r[7:0];
    o[1] = c[1] ^ r[15:8];
    o[2] = c[2] ^ r[7:0] ^ r[15:8];
    return o;
  endfunction

  function automatic shares_t sq_n(input shares_t a, input int n);
    shares_t o;
    o = a;
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        for (int i = 0; i < NUM_SHARES; i++) o[i] = gf_sq(o[i]);
      end
    end
    return o;
  endfunction

  shares_t a_in;
  shares_t a_p1_q, a_p1_d, n_p1_q, n_p1_d;
  shares_t a_p2_q, a_p2_d, n_p2_q, n_p2_d, t_p2_q, t_p2_d;
  shares_t a_p3_q, a_p3_d, u_p3_q, u_p3_d;
  shares_t y_p4_q, y_p4_d;
  shares_t inv_p4;
  logic    fwd_out;

`ifdef SBOX_INV_EN
  assign fwd_out = ~inv_i;
  always_comb begin
    a_in = x_i;
    if (inv_i) begin
      for (int i = 0; i < NUM_SHARES; i++) a_in[i] = aff_inv_lin(x_i[i]);
      a_in[0] = a_in[0] ^ AFF_INV_C;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign fwd_out    = 1'b1;
  assign a_in       = x_i;
`endif

  always_comb begin
    // stage 1: norm N = a * a^16
    a_p1_d = a_in;
    n_p1_d = reshare(ti_mul(a_in, sq_n(a_in, 4)), rnd_i);
    // stage 2: N^6 = N^2 * N^4
    a_p2_d = a_p1_q;
    n_p2_d = n_p1_q;
    t_p2_d = reshare(ti_mul(sq_n(n_p1_q, 1), sq_n(n_p1_q, 2)), rnd_i);
    // stage 3: N^14 = N^6 * N^8, the subfield inverse of N
    a_p3_d = a_p2_q;
    u_p3_d = reshare(ti_mul(t_p2_q, sq_n(n_p2_q, 3)), rnd_i);
    // stage 4: a^-1 = a^16 * N^14, then the output affine map
    inv_p4 = reshare(ti_mul(sq_n(a_p3_q, 4), u_p3_q), rnd_i);
    y_p4_d = inv_p4;
    if (fwd_out) begin
      for (int i = 0; i < NUM_SHARES; i++) y_p4_d[i] = aff_fwd_lin(inv_p4[i]);
      y_p4_d[0] = y_p4_d[0] ^ AFF_FWD_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1_q <= '0;
      n_p1_q <= '0;
      a_p2_q <= '0;
      n_p2_q <= '0;
      t_p2_q <= '0;
      a_p3_q <= '0;
      u_p3_q <= '0;
      y_p4_q <= '0;
    end else if (en_i) begin
      a_p1_q <= a_p1_d;
      n_p1_q <= n_p1_d;
      a_p2_q <= a_p2_d;
      n_p2_q <= n_p2_d;
      t_p2_q <= t_p2_d;
      a_p3_q <= a_p3_d;
      u_p3_q <= u_p3_d;
      y_p4_q <= y_p4_d;
    end
  end

  assign y_o = y_p4_q;

endmodule

// File: rtl/ti_sbox.sv
// Top: share loading FSM, mask LFSR and output share serializer around ti_sbox_core.
// Define SBOX_INV_EN to let uio_in[1] (sampled with share x0) select the inverse S-box.
module ti_sbox
  import ti_sbox_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  cnt_q, cnt_d;
  shares_t     x_q, x_d;
  logic        inv_q, inv_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        in_load, inv_sel, core_en, out_ready, busy;
  shares_t     y;
  logic        unused_in;

  assign in_load   = uio_in[0];
  assign unused_in = ^{ena, uio_in[7:1]};
`ifdef SBOX_INV_EN
  assign inv_sel = uio_in[1];
`else
  assign inv_sel = 1'b0;
`endif

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    inv_d   = inv_q;
    core_en = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (in_load) begin
          case (k_q)
            2'd0:    begin x_d[0] = ui_in; inv_d = inv_sel; end
            2'd1:    x_d[1] = ui_in;
            default: x_d[2] = ui_in;
          endcase
          if (k_q == 2'd2) begin
            state_d = CALC;
            cnt_d   = 2'd0;
          end else begin
            state_d = LOAD;
            k_d     = k_q + 2'd1;
          end
        end
      end
      CALC: begin
        core_en = 1'b1;
        if (cnt_q == 2'd3) begin
          state_d = OUT;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      OUT: begin
        if (cnt_q == 2'd2) begin
          state_d = IDLE;
          k_d     = 2'd0;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      cnt_q   <= 2'd0;
      x_q     <= '0;
      inv_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      inv_q   <= inv_d;
      lfsr_q  <= lfsr_d;
    end
  end

  ti_sbox_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (core_en),
    .inv_i (inv_q),
    .rnd_i (lfsr_q),
    .x_i   (x_q),
    .y_o   (y)
  );

  assign out_ready = (state_q == OUT);
  assign busy      = (state_q == CALC) || (state_q == OUT);

  always_comb begin
    uo_out = 8'h00;
    if (out_ready) begin
      case (cnt_q)
        2'd0:    uo_out = y[0];
        2'd1:    uo_out = y[1];
        default: uo_out = y[2];
      endcase
    end
  end

  assign uio_out = {3'b000, busy, out_ready, 3'b000};
  assign uio_oe  = 8'h18;

endmodule

// File: tb/tb_ti_sbox.sv
// Self-checking bench for ti_sbox: directed vectors plus random share splits against a table model.
module tb_ti_sbox;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  ti_sbox dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Schoolbook polynomial product followed by reduction modulo 0x11B.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_model();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[x] = s;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v, input logic inv);
    ui_in  = v;
    uio_in = {6'b000000, inv, 1'b1};
    step();
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic comp(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic inv, input int gap,
                      input logic junk, input logic [7:0] exp_y);
    logic [7:0] acc;
    int lat;
    load(s0, inv);
    idle(gap);
    load(s1, 1'b0);
    idle(gap);
    load(s2, 1'b0);
    if (junk) begin
      ui_in  = 8'h77;
      uio_in = 8'h01;
    end
    lat = 1;
    step();
    while (!uio_out[3] && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'd4);
    acc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, " out_ready"}, 32'(uio_out[3]), 32'd1);
      check_eq({tag, " busy"}, 32'(uio_out[4]), 32'd1);
      acc = acc ^ uo_out;
      step();
    end
    ui_in  = 8'h00;
    uio_in = 8'h00;
    check_eq({tag, " out_ready end"}, 32'(uio_out[3]), 32'd0);
    check_eq({tag, " busy end"}, 32'(uio_out[4]), 32'd0);
    check_eq({tag, " uo_out end"}, 32'(uo_out), 32'd0);
    check_eq({tag, " xor"}, 32'(acc), 32'(exp_y));
  endtask

  initial begin
    int rdy_cnt;
    logic [7:0] x, s0, s1, exp_y;
    logic inv;

    build_model();

    #3;
    check_eq("reset uo_out", 32'(uo_out), 32'h00);
    check_eq("reset uio_out", 32'(uio_out), 32'h00);
    check_eq("reset uio_oe", 32'(uio_oe), 32'h18);
    step();
    rst_n = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (uio_out[3]) rdy_cnt++;
    end
    check_eq("idle out_ready", 32'(rdy_cnt), 32'd0);

    comp("zero", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h63);
    comp("x53 gaps", 8'h12, 8'h41, 8'h00, 1'b0, 2, 1'b0, 8'hED);
    comp("xFF junk", 8'hAA, 8'h55, 8'h00, 1'b0, 0, 1'b1, 8'h16);
    comp("after junk", 8'h30, 8'h03, 8'h50, 1'b0, 1, 1'b0, sb[8'h63]);

    load(8'h5A, 1'b0);
    load(8'h11, 1'b0);
    load(8'h22, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #1;
    check_eq("abort uo_out", 32'(uo_out), 32'h00);
    check_eq("abort uio_out", 32'(uio_out), 32'h00);
    step();
    rst_n = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (uio_out[3]) rdy_cnt++;
    end
    check_eq("abort no ready", 32'(rdy_cnt), 32'd0);
    comp("x01", 8'h01, 8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h7C);

`ifdef SBOX_INV_EN
    comp("inv x63", 8'h21, 8'h42, 8'h00, 1'b1, 0, 1'b0, 8'h00);
`else
    comp("inv x63", 8'h21, 8'h42, 8'h00, 1'b1, 0, 1'b0, 8'hFB);
`endif

    for (int n = 0; n < 24; n++) begin
      x   = 8'($urandom_range(0, 255));
      s0  = 8'($urandom_range(0, 255));
      s1  = 8'($urandom_range(0, 255));
      inv = 1'($urandom_range(0, 1));
`ifdef SBOX_INV_EN
      exp_y = inv ? isb[x] : sb[x];
`else
      exp_y = sb[x];
`endif
      comp("random", s0, s1, x ^ s0 ^ s1, inv, $urandom_range(0, 2),
           1'($urandom_range(0, 1)), exp_y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
